// File: rtl/horner_eval_arbiter.sv
// Shares one horner_cubic_fsm evaluator between NUM_REQ AXI-stream requesters.
// Build option: define HORNER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module horner_eval_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int MAX_OUT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_tvalid,
    output logic [NUM_REQ-1:0]          req_tready,
    input  logic [NUM_REQ-1:0]          req_tlast,
    input  logic [NUM_REQ*DATA_W-1:0]   req_tdata,
    output logic                        ev_tvalid,
    input  logic                        ev_tready,
    output logic                        ev_tlast,
    output logic [DATA_W-1:0]           ev_tdata,
    input  logic                        res_tvalid,
    output logic                        res_tready,
    input  logic                        res_tlast,
    input  logic [DATA_W-1:0]           res_tdata,
    output logic [NUM_REQ-1:0]          rsp_tvalid,
    input  logic [NUM_REQ-1:0]          rsp_tready,
    output logic                        rsp_tlast,
    output logic [DATA_W-1:0]           rsp_tdata,
    output logic [$clog2(MAX_OUT):0]    outstanding,
    output logic                        err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT) + 1;

    typedef enum logic {ARB, SEND} state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   grant, grant_nx;
    logic [GW-1:0]   pick;
    logic            pick_ok;

    logic [GW-1:0]   tag_mem [MAX_OUT];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [GW-1:0]   head;
    logic            fifo_empty, fifo_full;
    logic            push, pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (outstanding == '0);
    assign fifo_full  = (outstanding == CW'(MAX_OUT));

`ifdef HORNER_ARB_FIXED_PRIO_EN
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!pick_ok && req_tvalid[i]) begin
                pick    = GW'(i);
                pick_ok = 1'b1;
            end
        end
    end
`else
    logic [GW-1:0] last_grant;
    logic [GW-1:0] idx;

    // Search starts one past the previous winner and wraps, so every requester gets a turn.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((32'(last_grant) + k) % NUM_REQ);
            if (!pick_ok && req_tvalid[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= GW'(NUM_REQ - 1);
        else if (push)
            last_grant <= grant;
    end
`endif

    assign push = (state == SEND) && req_tvalid[grant] && ev_tready && req_tlast[grant];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
            grant <= '0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        ev_tvalid  = 1'b0;
        ev_tlast   = 1'b0;
        ev_tdata   = '0;
        req_tready = '0;
        unique case (state)
            ARB: begin
                if (pick_ok && !fifo_full) begin
                    grant_nx = pick;
                    state_nx = SEND;
                end
            end
            SEND: begin
                ev_tvalid         = req_tvalid[grant];
                ev_tlast          = req_tlast[grant];
                ev_tdata          = req_tdata[grant*DATA_W +: DATA_W];
                req_tready[grant] = ev_tready;
                if (push)
                    state_nx = ARB;
            end
        endcase
    end

    // Result routing: the FIFO head names the requester that owns the packet now leaving the evaluator.
    assign head = tag_mem[rd_ptr];

    always_comb begin
        rsp_tvalid = '0;
        res_tready = 1'b0;
        if (!fifo_empty) begin
            rsp_tvalid[head] = res_tvalid;
            res_tready       = rsp_tready[head];
        end
    end

    assign rsp_tdata = res_tdata;
    assign rsp_tlast = res_tlast;
    assign pop       = res_tvalid && res_tready && res_tlast;

    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if ((res_tvalid && fifo_empty) || (push && !pop && fifo_full) || (pop && fifo_empty))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_horner_eval_arbiter.sv
// Directed bench for horner_eval_arbiter with a behavioural cubic evaluator (A=1,B=2,C=3.5,D=4.5).
module tb_horner_eval_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int MAX_OUT = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_tvalid, req_tready, req_tlast;
    logic [NUM_REQ*DATA_W-1:0] req_tdata;
    logic                      ev_tvalid, ev_tready, ev_tlast;
    logic [DATA_W-1:0]         ev_tdata;
    logic                      res_tvalid, res_tready, res_tlast;
    logic [DATA_W-1:0]         res_tdata;
    logic [NUM_REQ-1:0]        rsp_tvalid, rsp_tready;
    logic                      rsp_tlast;
    logic [DATA_W-1:0]         rsp_tdata;
    logic [$clog2(MAX_OUT):0]  outstanding;
    logic                      err;

    horner_eval_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_tvalid (req_tvalid),
        .req_tready (req_tready),
        .req_tlast  (req_tlast),
        .req_tdata  (req_tdata),
        .ev_tvalid  (ev_tvalid),
        .ev_tready  (ev_tready),
        .ev_tlast   (ev_tlast),
        .ev_tdata   (ev_tdata),
        .res_tvalid (res_tvalid),
        .res_tready (res_tready),
        .res_tlast  (res_tlast),
        .res_tdata  (res_tdata),
        .rsp_tvalid (rsp_tvalid),
        .rsp_tready (rsp_tready),
        .rsp_tlast  (rsp_tlast),
        .rsp_tdata  (rsp_tdata),
        .outstanding(outstanding),
        .err        (err)
    );

    always #5 clk = ~clk;

    real         req_x [NUM_REQ][8];
    int          req_n [NUM_REQ];
    int          req_h [NUM_REQ];
    logic [63:0] evq[$];
    int          evq_t[$];
    int          grant_log[$];
    int          rsp_who[$];
    logic [63:0] rsp_val[$];
    int          cyc, peak;
    logic        force_res;
    int          n_checks, n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] cubic(input logic [63:0] xb);
        real x;
        x = $bitstoreal(xb);
        return $realtobits(((1.0 * x + 2.0) * x + 3.5) * x + 4.5);
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_tvalid[i] = (req_h[i] < req_n[i]);
            req_tlast[i]  = 1'b1;
            req_tdata[i*DATA_W +: DATA_W] = req_tvalid[i] ? $realtobits(req_x[i][req_h[i]]) : '0;
        end
        res_tlast = 1'b1;
        if (force_res) begin
            res_tvalid = 1'b1;
            res_tdata  = $realtobits(99.0);
        end else if (evq.size() > 0 && evq_t[0] <= cyc) begin
            res_tvalid = 1'b1;
            res_tdata  = evq[0];
        end else begin
            res_tvalid = 1'b0;
            res_tdata  = '0;
        end
    endtask

    // Handshakes are observed at the falling edge; they complete on the following rising edge.
    task automatic step();
        logic [NUM_REQ-1:0] hs;
        @(negedge clk);
        hs = req_tvalid & req_tready;
        if (ev_tvalid && ev_tready) begin
            evq.push_back(cubic(ev_tdata));
            evq_t.push_back(cyc + 2);
            for (int i = 0; i < NUM_REQ; i++)
                if (req_tready[i]) grant_log.push_back(i);
        end
        if (res_tvalid && res_tready && !force_res && evq.size() > 0) begin
            void'(evq.pop_front());
            void'(evq_t.pop_front());
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_tvalid[i] && rsp_tready[i]) begin
                rsp_who.push_back(i);
                rsp_val.push_back(rsp_tdata);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_REQ; i++)
            if (hs[i]) req_h[i]++;
        drive();
        #1;
        if (int'(outstanding) > peak) peak = int'(outstanding);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_n[i] = 0;
            req_h[i] = 0;
        end
        evq.delete();
        evq_t.delete();
        force_res  = 1'b0;
        ev_tready  = 1'b1;
        rsp_tready = '1;
        drive();
        step();
        step();
        rst = 1'b0;
        grant_log.delete();
        rsp_who.delete();
        rsp_val.delete();
        peak = 0;
        drive();
        #1;
    endtask

    task automatic wait_rsp(input int n, input string tag);
        for (int k = 0; k < 200 && rsp_who.size() < n; k++) step();
        check(tag, rsp_who.size(), n);
    endtask

    initial begin
        real exp_v [4];
        int  exp_g [4];
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        peak      = 0;
        force_res = 1'b0;
        rst       = 1'b1;
        ev_tready = 1'b1;
        rsp_tready = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_n[i] = 0;
            req_h[i] = 0;
        end
        drive();
        do_reset();

        check("rst_ev_tvalid", ev_tvalid, 0);
        check("rst_req_tready", req_tready, 0);
        check("rst_rsp_tvalid", rsp_tvalid, 0);
        check("rst_res_tready", res_tready, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err, 0);

        // Single requester, x=2.0 -> 27.5
        req_x[0][0] = 2.0;
        req_n[0]    = 1;
        drive();
        #1;
        check("single_ev_idle", ev_tvalid, 0);
        step();
        check("single_ev_lat", ev_tvalid, 1);
        check("single_ev_data", ev_tdata, $realtobits(2.0));
        check("single_req_rdy", req_tready, 4'b0001);
        wait_rsp(1, "single_cnt");
        check("single_who", rsp_who[0], 0);
        check("single_val", rsp_val[0], $realtobits(27.5));
        step();
        check("single_out0", outstanding, 0);

        // All four at once
        do_reset();
        req_x[0][0] = 2.0;
        req_x[1][0] = 1.0;
        req_x[2][0] = 10.0;
        req_x[3][0] = -1.0;
        for (int i = 0; i < NUM_REQ; i++) req_n[i] = 1;
        drive();
        wait_rsp(4, "rr4_cnt");
        exp_v = '{27.5, 11.0, 1239.5, 2.0};
        for (int k = 0; k < 4; k++) begin
            check("rr4_grant", grant_log[k], k);
            check("rr4_who", rsp_who[k], k);
            check("rr4_val", rsp_val[k], $realtobits(exp_v[k]));
        end

        // req1 continuous, req2 competing
        do_reset();
        for (int j = 0; j < 3; j++) req_x[1][j] = 1.0;
        for (int j = 0; j < 2; j++) req_x[2][j] = 1.0;
        req_n[1] = 3;
        req_n[2] = 2;
        drive();
        wait_rsp(5, "alt_cnt");
`ifdef HORNER_ARB_FIXED_PRIO_EN
        exp_g = '{1, 1, 1, 2};
`else
        exp_g = '{1, 2, 1, 2};
`endif
        for (int k = 0; k < 4; k++) check("alt_grant", grant_log[k], exp_g[k]);

        // Tag FIFO full: rsp_tready[0] held low
        do_reset();
        rsp_tready = 4'b1110;
        for (int j = 0; j < 5; j++) req_x[0][j] = 1.0;
        req_n[0] = 5;
        drive();
        for (int k = 0; k < 40; k++) step();
        check("full_peak", peak, 4);
        check("full_out", outstanding, 4);
        check("full_grants", grant_log.size(), 4);
        check("full_req_rdy", req_tready, 0);
        check("full_ev_tvalid", ev_tvalid, 0);
        rsp_tready = '1;
        drive();
        wait_rsp(5, "full_cnt");
        check("full_grants5", grant_log.size(), 5);
        check("full_val", rsp_val[4], $realtobits(11.0));
        check("full_who", rsp_who[4], 0);

        // Result with empty FIFO
        do_reset();
        force_res = 1'b1;
        drive();
        #1;
        check("err_res_rdy", res_tready, 0);
        check("err_rsp_tvalid", rsp_tvalid, 0);
        check("err_pre", err, 0);
        step();
        check("err_set", err, 1);
        force_res = 1'b0;
        drive();
        step();
        step();
        check("err_sticky", err, 1);
        do_reset();
        check("err_clr", err, 0);

        // Reset while req2 is in SEND
        do_reset();
        ev_tready   = 1'b0;
        req_x[2][0] = 10.0;
        req_n[2]    = 1;
        drive();
        step();
        check("mid_ev_tvalid", ev_tvalid, 1);
        check("mid_ev_data", ev_tdata, $realtobits(10.0));
        rst         = 1'b1;
        req_x[0][0] = -1.0;
        req_n[0]    = 1;
        drive();
        step();
        check("mid_rst_ev_tvalid", ev_tvalid, 0);
        check("mid_rst_req_rdy", req_tready, 0);
        check("mid_rst_rsp_tvalid", rsp_tvalid, 0);
        check("mid_rst_res_rdy", res_tready, 0);
        check("mid_rst_out", outstanding, 0);
        rst       = 1'b0;
        ev_tready = 1'b1;
        step();
        check("post_rst_grant", req_tready, 4'b0001);
        check("post_rst_data", ev_tdata, $realtobits(-1.0));
        wait_rsp(2, "post_rst_cnt");
        check("post_rst_who0", rsp_who[0], 0);
        check("post_rst_val0", rsp_val[0], $realtobits(2.0));
        check("post_rst_who1", rsp_who[1], 2);
        check("post_rst_val1", rsp_val[1], $realtobits(1239.5));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
